// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit add/subtract unit sequencing a single one-bit full-adder slice.
// Operands are consumed LSB first; completion raises done for one cycle with carry and overflow flags.

module bit_alu (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic ctrl,
  output logic ans,
  output logic cout
);
  logic b_eff;

  assign b_eff = b ^ ctrl;
  assign ans   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
endmodule

module serial_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [CNT_W-1:0] cnt;
  logic             ctrl_q;
  logic             carry_q;
  logic             bit_ans;
  logic             bit_cout;
  logic [WIDTH-1:0] r_cat;
  logic             last_bit;

  bit_alu u_bit_alu (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .ctrl (ctrl_q),
    .ans  (bit_ans),
    .cout (bit_cout)
  );

  // Result bits enter at the top and walk down; the last ANS completes the word.
  assign r_cat    = {bit_ans, r_sh};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STATE_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      cnt     <= '0;
      ctrl_q  <= 1'b0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            ctrl_q  <= ctrl;
            // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
            carry_q <= ctrl;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= STATE_RUN;
          end
        end
        STATE_RUN: begin
          r_sh    <= r_cat[WIDTH-1:1];
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= bit_cout;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            result <= r_cat;
            cout   <= bit_cout;
            // Carry into the MSB differs from carry out exactly on signed overflow.
            ovf    <= carry_q ^ bit_cout;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu.sv
// Randomized and directed bench for serial_alu (WIDTH=8) against an arithmetic reference model.
`timescale 1ns/1ps

module tb_serial_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ctrl = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ctrl   (ctrl),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {ovf, cout, result}.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
    int ua, ub, sa, sb, ures, sres;
    logic [7:0] r;
    logic c, v;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (mc) begin
      ures = ua - ub;
      sres = sa - sb;
      c = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c = (ures > 255);
    end
    r = 8'(ures);
    v = (sres > 127) || (sres < -128);
    return {v, c, r};
  endfunction

  // Drives one operation and measures it; operands are scrambled during RUN.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                        output int lat, output int busy_err,
                        output logic [7:0] res, output logic co, output logic ov);
    @(negedge clk);
    a = oa; b = ob; ctrl = oc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); ctrl = 1'($urandom);
    lat = 1;
    busy_err = 0;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_err++;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) busy_err++;
    res = result; co = cout; ov = ovf;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result: got %02h expected 00", result); end
    checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {cout, ovf}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [6];
    logic [7:0] tb [6];
    logic       tc [6];
    logic [7:0] er [6];
    logic       ec [6];
    logic       ev [6];
    int lat, berr;
    logic [7:0] res;
    logic co, ov;
    ta = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h00};
    tb = '{8'h05, 8'h01, 8'h01, 8'h07, 8'h01, 8'h00};
    tc = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    er = '{8'h41, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00};
    ec = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    ev = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, berr, res, co, ov);
      checks++; if (lat != W + 1) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, W + 1); end
      checks++; if (berr != 0) begin failures++; $display("FAIL dir%0d_busy: got %0d bad cycles expected 0", i, berr); end
      checks++; if (res !== er[i]) begin failures++; $display("FAIL dir%0d_result: got %02h expected %02h", i, res, er[i]); end
      checks++; if ({co, ov} !== {ec[i], ev[i]}) begin failures++; $display("FAIL dir%0d_flags: got cout=%b ovf=%b expected cout=%b ovf=%b", i, co, ov, ec[i], ev[i]); end
    end
  endtask

  task automatic test_random();
    int lat, berr;
    logic [7:0] ra, rb, res;
    logic rc, co, ov;
    logic [9:0] exp_v;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp_v = model(ra, rb, rc);
      run_op(ra, rb, rc, lat, berr, res, co, ov);
      checks++;
      if (lat != W + 1 || berr != 0 || {ov, co, res} !== exp_v) begin
        failures++;
        $display("FAIL rand%0d a=%02h b=%02h ctrl=%b: got lat=%0d busyerr=%0d {ovf,cout,res}=%03h expected lat=%0d busyerr=0 %03h",
                 i, ra, rb, rc, lat, berr, {ov, co, res}, W + 1, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [9:0] exp_v;
    @(negedge clk);
    a = 8'h10; b = 8'h20; ctrl = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; ctrl = 1'b1;
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (lat != W + 1) begin failures++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (result !== 8'h30) begin failures++; $display("FAIL b2b_first_result: got %02h expected 30", result); end
    // start is still high here, so the edge ending the done cycle accepts the next op.
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    exp_v = model(8'hAA, 8'h55, 1'b1);
    checks++; if (lat != W + 1) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if ({ovf, cout, result} !== exp_v) begin failures++; $display("FAIL b2b_second_result: got %03h expected %03h", {ovf, cout, result}, exp_v); end
    checks++; if ({cout, result} !== {1'b1, 8'h55}) begin failures++; $display("FAIL b2b_second_const: got cout=%b res=%02h expected cout=1 res=55", cout, result); end
  endtask

  task automatic test_reset_mid();
    int lat, berr;
    logic [7:0] res;
    logic co, ov;
    @(negedge clk);
    a = 8'h12; b = 8'h34; ctrl = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if ({result, cout, ovf} !== 10'h000) begin failures++; $display("FAIL midrst_outputs: got res=%02h cout=%b ovf=%b expected 00 0 0", result, cout, ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, lat, berr, res, co, ov);
    checks++; if (lat != W + 1) begin failures++; $display("FAIL midrst_after_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if ({res, co, ov} !== {8'h02, 2'b00}) begin failures++; $display("FAIL midrst_after_result: got res=%02h cout=%b ovf=%b expected 02 0 0", res, co, ov); end
  endtask

  task automatic test_hold();
    int lat, berr, bad;
    logic [7:0] res;
    logic co, ov;
    run_op(8'h3C, 8'h05, 1'b0, lat, berr, res, co, ov);
    checks++; if (res !== 8'h41) begin failures++; $display("FAIL hold_setup: got %02h expected 41", res); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); ctrl = 1'($urandom); start = 1'b0;
      if (result !== 8'h41 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_idle: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
